// File: rtl/shift_box_pkg.sv
// Shared types and widths for the iterative shift/rotate unit.
package shift_box_pkg;

  localparam int unsigned SHIFT_W = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SLL  = 3'b010,
    OP_SRL  = 3'b011,
    OP_SRA  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_RSVD = 3'b111
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

  // True for the ops that actually move bits (SLL..ROL).
  function automatic logic is_shift_op(shift_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) ||
           (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_passo.sv
// One single-bit step of a shift or rotate; non-shift ops pass the value through.
module shift_passo
  import shift_box_pkg::*;
(
  input  logic [SHIFT_W-1:0] valor_i,
  input  shift_op_t          op_i,
  output logic [SHIFT_W-1:0] passo_o
);

  always_comb begin
    passo_o = valor_i;
    case (op_i)
      OP_SLL:  passo_o = {valor_i[SHIFT_W-2:0], 1'b0};
      OP_SRL:  passo_o = {1'b0, valor_i[SHIFT_W-1:1]};
      OP_SRA:  passo_o = {valor_i[SHIFT_W-1], valor_i[SHIFT_W-1:1]};
      OP_ROR:  passo_o = {valor_i[0], valor_i[SHIFT_W-1:1]};
      OP_ROL:  passo_o = {valor_i[SHIFT_W-2:0], valor_i[SHIFT_W-1]};
      default: passo_o = valor_i;
    endcase
  end

endmodule

// File: rtl/shift_box_iterativo.sv
// Iterative 32-bit shift/rotate unit: one bit per clock, start/done handshake
// with the multicycle control FSM.
module shift_box_iterativo
  import shift_box_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [SHIFT_W-1:0] entrada,
  output logic [SHIFT_W-1:0] saida,
  output logic               busy,
  output logic               done
);

  shift_state_t       state_q;
  shift_op_t          op_q;
  logic [SHAMT_W-1:0] count_q;
  logic [SHIFT_W-1:0] sreg_q;
  logic [SHIFT_W-1:0] passo_d;
  shift_op_t          op_in;

  assign op_in = shift_op_t'(op);

  shift_passo u_passo (
    .valor_i (sreg_q),
    .op_i    (op_q),
    .passo_o (passo_d)
  );

  // Control FSM with count and shift register; inputs are only looked at in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      count_q <= '0;
      sreg_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op_in;
            count_q <= shamt;
            if (is_shift_op(op_in) || (op_in == OP_LOAD)) begin
              sreg_q <= entrada;
            end
            if (is_shift_op(op_in) && (shamt != '0)) begin
              state_q <= ST_SHIFT;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          sreg_q  <= passo_d;
          count_q <= count_q - SHAMT_W'(1);
          if (count_q == SHAMT_W'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Status decoded from registered state only.
  assign saida = sreg_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_box_iterativo.sv
// Self-checking bench for shift_box_iterativo: vector table plus scoreboard queue.
module tb_shift_box_iterativo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [4:0]  shamt;
  logic [31:0] entrada;
  logic [31:0] saida;
  logic        busy;
  logic        done;

  int n_total  = 0;
  int n_passed = 0;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] entrada;
    logic [31:0] exp_saida;
    int          exp_cyc;
    int          inj_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] saida;
    int          cyc;
  } exp_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  exp_t sb [$];

  shift_box_iterativo dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .entrada (entrada),
    .saida   (saida),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic run_op(input vec_t v, input string name);
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    op = v.op; shamt = v.shamt; entrada = v.entrada; start = 1'b1;
    sb.push_back('{v.exp_saida, v.exp_cyc});
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    seen  = 1'b0;
    while (!seen && cyc <= 40) begin
      chk({name, " busy"}, 32'(busy), 32'(cyc <= v.exp_cyc));
      if (done) begin
        e = sb.pop_front();
        chk({name, " saida"}, saida, e.saida);
        chk({name, " done_cycle"}, 32'(cyc), 32'(e.cyc));
        seen = 1'b1;
      end else begin
        if (cyc == v.inj_cyc) begin
          op = 3'b001; shamt = 5'd0; entrada = 32'hFFFF_FFFF; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
    chk({name, " idle_busy"}, 32'(busy), 32'd0);
    chk({name, " idle_done"}, 32'(done), 32'd0);
    chk({name, " hold"}, saida, v.exp_saida);
  endtask

  initial begin
    vecs[0]  = '{3'b001, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1,  0};  // LOAD
    vecs[1]  = '{3'b000, 5'd3,  32'h1111_1111, 32'hDEAD_BEEF, 1,  0};  // NOP
    vecs[2]  = '{3'b010, 5'd4,  32'h0000_000F, 32'h0000_00F0, 5,  3};  // SLL + ignored start
    vecs[3]  = '{3'b100, 5'd8,  32'h8000_0000, 32'hFF80_0000, 9,  0};  // SRA
    vecs[4]  = '{3'b011, 5'd8,  32'h8000_0000, 32'h0080_0000, 9,  0};  // SRL
    vecs[5]  = '{3'b101, 5'd31, 32'h0000_0001, 32'h0000_0002, 32, 0};  // ROR 31
    vecs[6]  = '{3'b110, 5'd1,  32'h8000_0001, 32'h0000_0003, 2,  0};  // ROL 1
    vecs[7]  = '{3'b010, 5'd0,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 1,  0};  // SLL by 0
    vecs[8]  = '{3'b111, 5'd5,  32'h0000_0055, 32'hA5A5_A5A5, 1,  0};  // reserved
    vecs[9]  = '{3'b101, 5'd4,  32'h0000_000F, 32'hF000_0000, 5,  0};  // ROR 4
    vecs[10] = '{3'b110, 5'd8,  32'h1234_5678, 32'h3456_7812, 9,  0};  // ROL 8
    vecs[11] = '{3'b100, 5'd4,  32'h7F00_0000, 32'h07F0_0000, 5,  0};  // SRA positive

    reset_n = 1'b1; start = 1'b0; op = '0; shamt = '0; entrada = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst saida", saida, 32'h0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst saida", saida, 32'h0);
    chk("post_rst busy", 32'(busy), 32'd0);

    for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an SRL by 16.
    @(negedge clk);
    op = 3'b011; shamt = 5'd16; entrada = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst pre saida", saida, 32'h3FFF_FFFF);
    chk("midrst pre busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst saida", saida, 32'h0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("midrst idle busy", 32'(busy), 32'd0);
    run_op('{3'b001, 5'd0, 32'h1234_5678, 32'h1234_5678, 1, 0}, "load_after_rst");

    chk("sb empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
